subway_sched: RTL and testbench

SUBWAY_SCHED -- requirements
Module: subway_sched

---
 rtl/subway_sched_if.sv | 30 +++
 rtl/subway_sched.sv | 115 +++++++++++
 tb/tb_subway_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/subway_sched_if.sv
// Bundle of map-input, planner and move-output signals for subway_sched.
// The slave modport is the scheduler; the master modport is the environment around it.
interface subway_sched_if;
  logic       in_valid;
  logic [1:0] init;
  logic [1:0] in0;
  logic [1:0] in1;
  logic [1:0] in2;
  logic [1:0] in3;
  logic       pl_start;
  logic [1:0] pl_init;
  logic       rd_req;
  logic [5:0] rd_col;
  logic       rd_gnt;
  logic [7:0] rd_data;
  logic       mv_valid;
  logic [1:0] mv;
  logic       out_valid;
  logic [1:0] out;

  modport slave (
    input  in_valid, init, in0, in1, in2, in3, rd_req, rd_col, mv_valid, mv,
    output pl_start, pl_init, rd_gnt, rd_data, out_valid, out
  );

  modport master (
    output in_valid, init, in0, in1, in2, in3, rd_req, rd_col, mv_valid, mv,
    input  pl_start, pl_init, rd_gnt, rd_data, out_valid, out
  );
endinterface

// File: rtl/subway_sched.sv
// Subway game scheduler: buffers up to 64 map columns, serves planner reads,
// collects 63 planner moves and replays them as a contiguous output stream.
module subway_sched #(
  parameter int LOOKAHEAD = 8
) (
  input logic           clk,
  input logic           rst_n,
  subway_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t     r_state;
  logic [7:0] r_map   [0:63];
  logic [1:0] r_moves [0:62];
  logic [6:0] r_wrCnt;
  logic [5:0] r_mvCnt;
  logic [5:0] r_outIdx;
  logic       r_plStart;
  logic [1:0] r_plInit;
  logic       r_rdGnt;
  logic [7:0] r_rdData;
  logic       r_outValid;
  logic [1:0] r_out;

  logic [7:0] w_col;
  logic       w_colWe;
  logic       w_mvWe;
  logic [6:0] w_wrNext;

  // Columns are accepted in every state until the map is full; in IDLE the count is 0, so
  // the first column of a game lands at index 0 through the same path.
  assign w_col    = {bus.in3, bus.in2, bus.in1, bus.in0};
  assign w_colWe  = bus.in_valid && (r_wrCnt < 7'd64);
  assign w_wrNext = r_wrCnt + 7'(w_colWe);
  assign w_mvWe   = (r_state == RUN) && bus.mv_valid && (r_mvCnt < 6'd63);

  always_ff @(posedge clk) begin
    if (w_colWe) r_map[r_wrCnt[5:0]] <= w_col;
    if (w_mvWe)  r_moves[r_mvCnt]    <= bus.mv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wrCnt    <= '0;
      r_mvCnt    <= '0;
      r_outIdx   <= '0;
      r_plStart  <= 1'b0;
      r_plInit   <= '0;
      r_rdGnt    <= 1'b0;
      r_rdData   <= '0;
      r_outValid <= 1'b0;
      r_out      <= '0;
    end else begin
      r_plStart <= 1'b0;
      r_rdGnt   <= 1'b0;
      r_rdData  <= '0;
      r_wrCnt   <= w_wrNext;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_plInit <= bus.init;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          if (w_wrNext >= 7'(LOOKAHEAD)) begin
            r_state   <= RUN;
            r_plStart <= 1'b1;
          end
        end
        RUN: begin
          // Compare against the pre-edge count so a column written this edge is not readable.
          if (bus.rd_req && ({1'b0, bus.rd_col} < r_wrCnt)) begin
            r_rdGnt  <= 1'b1;
            r_rdData <= r_map[bus.rd_col];
          end
          if (w_mvWe) begin
            r_mvCnt <= r_mvCnt + 6'd1;
            if (r_mvCnt == 6'd62) begin
              r_state    <= OUT;
              r_outValid <= 1'b1;
              r_out      <= r_moves[0];
              r_outIdx   <= 6'd1;
            end
          end
        end
        OUT: begin
          if (r_outIdx == 6'd63) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_out      <= '0;
            r_outIdx   <= '0;
            r_wrCnt    <= '0;
            r_mvCnt    <= '0;
            r_plInit   <= '0;
          end else begin
            r_out    <= r_moves[r_outIdx];
            r_outIdx <= r_outIdx + 6'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pl_start  = r_plStart;
  assign bus.pl_init   = r_plInit;
  assign bus.rd_gnt    = r_rdGnt;
  assign bus.rd_data   = r_rdData;
  assign bus.out_valid = r_outValid;
  assign bus.out       = r_out;

endmodule

// File: tb/tb_subway_sched.sv
// Directed bench for subway_sched: three games covering load, planner reads,
// move replay, late inputs, back-to-back games and a mid-replay reset.
module tb_subway_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failures = 0;

  subway_sched_if bus ();

  subway_sched #(.LOOKAHEAD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Lane l of column k for a given game: ((k >> 2l) + seed + l) mod 4.
  function automatic logic [7:0] colData(input int k, input int seed);
    logic [7:0] c;
    c = '0;
    for (int l = 0; l < 4; l++) c[2*l +: 2] = 2'((k >> (2*l)) + seed + l);
    return c;
  endfunction

  function automatic logic [1:0] moveCode(input int mode, input int k);
    return (mode == 0) ? 2'(k % 4) : 2'(3 - (k % 4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ini, input logic [7:0] col,
                               input logic rq, input logic [5:0] rc,
                               input logic mvv, input logic [1:0] m);
    bus.in_valid = v;
    bus.init     = ini;
    {bus.in3, bus.in2, bus.in1, bus.in0} = col;
    bus.rd_req   = rq;
    bus.rd_col   = rc;
    bus.mv_valid = mvv;
    bus.mv       = m;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 6'd0, 1'b0, 2'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadGame(input logic [1:0] ini, input int seed);
    for (int k = 0; k < 64; k++) begin
      logic       rq;
      logic [5:0] rc;
      rq = 1'b0;
      rc = 6'd0;
      if (k == 3) rq = 1'b1;
      if (k == 12 || k == 21) begin rq = 1'b1; rc = 6'd20; end
      if (k == 22) begin rq = 1'b1; rc = 6'd22; end
      applyStimulus(1'b1, (k == 0) ? ini : ~ini, colData(k, seed), rq, rc, 1'b0, 2'd0);
      if (k == 0) checkOutput("pl_init_latch", 32'(bus.pl_init), 32'(ini));
      if (k == 3) checkOutput("load_rd_gnt", 32'(bus.rd_gnt), 0);
      if (k == 6) checkOutput("pl_start_early", 32'(bus.pl_start), 0);
      if (k == 7) begin
        checkOutput("pl_start", 32'(bus.pl_start), 1);
        checkOutput("pl_init", 32'(bus.pl_init), 32'(ini));
      end
      if (k == 8) checkOutput("pl_start_pulse", 32'(bus.pl_start), 0);
      if (k == 12) begin
        checkOutput("rd_gnt_c20_early", 32'(bus.rd_gnt), 0);
        checkOutput("rd_data_c20_early", 32'(bus.rd_data), 0);
      end
      if (k == 21) begin
        checkOutput("rd_gnt_c20", 32'(bus.rd_gnt), 1);
        checkOutput("rd_data_c20", 32'(bus.rd_data), 32'(colData(20, seed)));
      end
      if (k == 22) checkOutput("rd_no_bypass", 32'(bus.rd_gnt), 0);
      if (k == 63) checkOutput("pl_init_hold", 32'(bus.pl_init), 32'(ini));
    end
  endtask

  task automatic sendMoves(input int mode, input int seed);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 6'd63, 1'b0, 2'd0);
    checkOutput("rd_gnt_c63", 32'(bus.rd_gnt), 1);
    checkOutput("rd_data_c63", 32'(bus.rd_data), 32'(colData(63, seed)));
    for (int k = 0; k < 63; k++) begin
      if (k == 30) idle();
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 6'd0, 1'b1, moveCode(mode, k));
      if (k == 61) checkOutput("out_early", 32'(bus.out_valid), 0);
    end
  endtask

  task automatic checkStream(input int mode, input int abortAt, input int extrasAt);
    for (int j = 0; j < 63; j++) begin
      checkOutput($sformatf("out_valid_%0d", j), 32'(bus.out_valid), 1);
      checkOutput($sformatf("out_%0d", j), 32'(bus.out), 32'(moveCode(mode, j)));
      if (j == abortAt) begin
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 0);
        checkOutput("abort_out", 32'(bus.out), 0);
        checkOutput("abort_pl_init", 32'(bus.pl_init), 0);
        for (int i = 0; i < 3; i++) begin
          idle();
          checkOutput($sformatf("abort_quiet_%0d", i), 32'(bus.out_valid), 0);
        end
        return;
      end
      if (j == extrasAt) begin
        applyStimulus(1'b1, 2'd3, 8'hFF, 1'b1, 6'd0, 1'b1, ~moveCode(mode, j));
        checkOutput("out_rd_gnt", 32'(bus.rd_gnt), 0);
      end else if (j == 62) begin
        applyStimulus(1'b1, 2'd3, 8'hAA, 1'b0, 6'd0, 1'b0, 2'd0);
      end else begin
        idle();
      end
    end
    checkOutput("end_out_valid", 32'(bus.out_valid), 0);
    checkOutput("end_out", 32'(bus.out), 0);
    checkOutput("end_pl_init", 32'(bus.pl_init), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.init     = 2'd0;
    bus.in0      = 2'd0;
    bus.in1      = 2'd0;
    bus.in2      = 2'd0;
    bus.in3      = 2'd0;
    bus.rd_req   = 1'b0;
    bus.rd_col   = 6'd0;
    bus.mv_valid = 1'b0;
    bus.mv       = 2'd0;
    idle();
    idle();
    checkOutput("rst_pl_start", 32'(bus.pl_start), 0);
    checkOutput("rst_pl_init", 32'(bus.pl_init), 0);
    checkOutput("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    checkOutput("rst_rd_data", 32'(bus.rd_data), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_out", 32'(bus.out), 0);
    rst_n = 1'b1;
    idle();
    checkOutput("idle_out_valid", 32'(bus.out_valid), 0);

    // Game 1, then game 2 starting in the very first IDLE cycle, aborted mid-replay.
    loadGame(2'd2, 0);
    sendMoves(0, 0);
    checkStream(0, -1, 5);
    loadGame(2'd1, 1);
    sendMoves(1, 1);
    checkStream(1, 10, -1);

    // Game 3 must run cleanly after the abort.
    loadGame(2'd3, 2);
    sendMoves(0, 2);
    checkStream(0, -1, 40);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("final_quiet_%0d", i), 32'(bus.out_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
